// File: rtl/ef_solver_pkg.sv
// Shared types and widths for the E/F truth-table solver.
package ef_solver_pkg;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned IDX_LAST = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ef_solver_if.sv
// Request / result bundle between the solver and its controller.
interface ef_solver_if
  import ef_solver_pkg::*;
;
  logic             start;
  logic             target_e;
  logic             target_f;
  logic             ready;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_abcd;
  logic             done;
  logic [CNT_W-1:0] match_count;

  modport master (
    output start, target_e, target_f, out_ready,
    input  ready, out_valid, out_abcd, done, match_count
  );

  modport slave (
    input  start, target_e, target_f, out_ready,
    output ready, out_valid, out_abcd, done, match_count
  );
endinterface

// File: rtl/ef_eval.sv
// Combinational E/F evaluation of one input vector {A,B,C,D}.
module ef_eval
  import ef_solver_pkg::*;
(
  input  logic [IDX_W-1:0] abcd,
  output logic             e,
  output logic             f
);
  logic a, b, c, d;

  assign {a, b, c, d} = abcd;
  assign e = a | (b & c) | (~b & d);
  assign f = (~b & c) | (b & ~c & ~d);
endmodule

// File: rtl/ef_solver.sv
// Scans all 16 ABCD vectors and hands off every one whose (E,F) matches the target.
// Optional match counter is enabled by defining EF_SOLVER_MATCH_COUNT_EN.
module ef_solver
  import ef_solver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  ef_solver_if.slave  bus
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] abcd_q, abcd_d;
  logic             tgt_e_q, tgt_e_d;
  logic             tgt_f_q, tgt_f_d;
  logic             ready_q, valid_q, done_q;
  logic             e_c, f_c, hit_c, last_c, accept_c, handshake_c;

  ef_eval u_eval (
    .abcd (idx_q),
    .e    (e_c),
    .f    (f_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    abcd_d      = abcd_q;
    tgt_e_d     = tgt_e_q;
    tgt_f_d     = tgt_f_q;
    handshake_c = 1'b0;
    accept_c    = (state_q == IDLE) && bus.start;
    hit_c       = (e_c == tgt_e_q) && (f_c == tgt_f_q);
    last_c      = (idx_q == IDX_W'(IDX_LAST));

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          tgt_e_d = bus.target_e;
          tgt_f_d = bus.target_f;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit_c) begin
          abcd_d  = idx_q;
          state_d = EMIT;
        end else if (last_c) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      EMIT: begin
        handshake_c = bus.out_ready;
        if (handshake_c) begin
          if (last_c) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abcd_q  <= '0;
      tgt_e_q <= 1'b0;
      tgt_f_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abcd_q  <= abcd_d;
      tgt_e_q <= tgt_e_d;
      tgt_f_q <= tgt_f_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == EMIT);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_abcd  = abcd_q;
  assign bus.done      = done_q;

`ifdef EF_SOLVER_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Cleared on an accepted start, bumped on each hand-off, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= '0;
    end else if (handshake_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_count = cnt_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: doc/ef_solver.md
EF_SOLVER -- requirements
Module: ef_solver

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge clock; all state is clocked on it.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low, synchronous release.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 target_e  input  1  wanted E value; latched when start is accepted.
REQ-006 target_f  input  1  wanted F value; latched when start is accepted.
REQ-007 ready  output  1  high exactly in IDLE.
REQ-008 out_valid  output  1  high exactly in EMIT; out_abcd holds a matching input vector.
REQ-009 out_ready  input  1  consumer accepts out_abcd when out_valid&&out_ready.
REQ-010 out_abcd  output  4  matching vector, A=bit3, B=bit2, C=bit1, D=bit0.
REQ-011 done  output  1  one-cycle pulse when a scan completes.
REQ-012 match_count  output  5  number of vectors handed off in the current or last scan, range 0..16.

Function
REQ-013 The block SHALL enumerate idx=0..15 and emit, in ascending order, every idx whose (E,F) equals the latched target.
REQ-014 The block SHALL compute E = A | (B&C) | (~B&D).
REQ-015 The block SHALL compute F = (~B&C) | (B&~C&~D).
REQ-016 The FSM SHALL have the states IDLE, SCAN, EMIT and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch the target, clear idx and match_count, and enter SCAN next cycle.
REQ-018 In SCAN on a mismatch, the block SHALL go to DONE if idx==15, else increment idx and stay in SCAN.
REQ-019 In SCAN on a match, the block SHALL register out_abcd=idx and enter EMIT.
REQ-020 In EMIT, out_valid and out_abcd SHALL stay stable until out_ready=1.
REQ-021 On the EMIT handshake, match_count SHALL increment and the FSM SHALL go to DONE if idx==15, else to SCAN with idx+1.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 start SHALL be ignored outside IDLE; the target inputs SHALL be ignored except on acceptance.
REQ-024 With out_ready held 1, a scan SHALL take exactly 16+M cycles from the first SCAN cycle to DONE, where M is the match count.
REQ-025 idx SHALL NOT wrap; the scan ends after idx 15 is resolved.
REQ-026 out_abcd SHALL hold its last value outside EMIT.
REQ-027 match_count SHALL hold after DONE until the next accepted start.

Reset
REQ-028 While rst_n=0, the FSM SHALL be in IDLE with idx=0, out_abcd=0, match_count=0, out_valid=0, done=0 and ready=1, including when reset asserts mid-scan or mid-EMIT.
REQ-029 No output SHALL glitch to a non-reset value during reset; the first accepted start SHALL be at the first rising edge with rst_n=1.

Configuration
REQ-030 The macro EF_SOLVER_MATCH_COUNT_EN SHALL control the match counter.
REQ-031 With EF_SOLVER_MATCH_COUNT_EN defined, match_count SHALL behave per REQ-012/021/027.
REQ-032 Without EF_SOLVER_MATCH_COUNT_EN, the counter register SHALL be omitted, match_count SHALL be tied to 0, and the port SHALL remain present.

Structure
REQ-033 The shared package ef_solver_pkg SHALL hold the state enum (IDLE, SCAN, EMIT, DONE), IDX_W=4, CNT_W=5 and IDX_LAST=15.
REQ-034 The E/F logic SHALL be one combinational sub-module, ef_eval (in abcd[3:0], out e, f), instantiated once on idx.
REQ-035 The FSM, idx counter, target latch and match counter SHALL be in ef_solver.

Verification
REQ-036 Target (0,0), out_ready=1: the bench SHALL see emits 0 then 5, match_count=2, and done in the cycle after the 18th scan cycle.
REQ-037 Target (1,1): the bench SHALL see emits 3, 10, 11, 12 and match_count=4.
REQ-038 Target (1,0) with out_ready stalled 3 cycles at each match: the bench SHALL see emits 1, 6, 7, 8, 9, 13, 14, 15, a stable out_abcd during stalls and match_count=8.
REQ-039 Target (0,1) with start pulsed again mid-scan: the bench SHALL see the second start ignored, emits 2 then 4, and match_count=2.
REQ-040 rst_n asserted in EMIT at idx=6: the bench SHALL see out_valid fall immediately, ready=1 and match_count=0; a new scan from start SHALL then complete normally.
REQ-041 A build without EF_SOLVER_MATCH_COUNT_EN, target (1,1): the bench SHALL see the same emits as REQ-037 and match_count=0 throughout.
